// File: rtl/morse_if.sv
// morse_if: request/status bundle between the keypad capture side and the Morse encoder
// start/key_val: character request from the master; busy/morse_out/done: encoder status and sounder line
interface morse_if;
  logic       start;
  logic [3:0] key_val;
  logic       busy;
  logic       morse_out;
  logic       done;
  modport master (output start, key_val, input busy, morse_out, done);
  modport slave  (input start, key_val, output busy, morse_out, done);
endinterface

// File: rtl/morse_encoder.sv
// morse_encoder: plays the Morse code of a hex key value on a single on/off line
// clk: system clock; rst: async active-low reset
// bus.start/bus.key_val: accepted while idle; bus.busy: character in progress;
// bus.morse_out: 1 = mark; bus.done: one-cycle pulse after the trailing character gap
module morse_encoder #(
  parameter int UNIT_CYCLES = 3_000_000
) (
  input logic   clk,
  input logic   rst,
  morse_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MARK, SPACE, CHAR_GAP} state_t;
  localparam logic [25:0] UNIT_LAST = 26'(UNIT_CYCLES - 1);
  state_t      state_q, state_d;
  logic [3:0]  key_q, key_d;
  logic [2:0]  idx_q, idx_d;
  logic [25:0] pre_q, pre_d;
  logic [1:0]  unit_q, unit_d;
  logic        busy_q, busy_d, mo_q, mo_d, done_q, done_d;
  logic [2:0]  len;
  logic [4:0]  pat;
  logic [1:0]  last;
  logic        dash, tick, unit_end;
  // elements are left-aligned: element i lives in pat[4-i]
  always_comb begin
    {len, pat} = 8'h0;
    case (key_q)
      4'h0: {len, pat} = {3'd5, 5'b11111};
      4'h1: {len, pat} = {3'd5, 5'b01111};
      4'h2: {len, pat} = {3'd5, 5'b00111};
      4'h3: {len, pat} = {3'd5, 5'b00011};
      4'h4: {len, pat} = {3'd5, 5'b00001};
      4'h5: {len, pat} = {3'd5, 5'b00000};
      4'h6: {len, pat} = {3'd5, 5'b10000};
      4'h7: {len, pat} = {3'd5, 5'b11000};
      4'h8: {len, pat} = {3'd5, 5'b11100};
      4'h9: {len, pat} = {3'd5, 5'b11110};
      4'hA: {len, pat} = {3'd2, 5'b01000};
      4'hB: {len, pat} = {3'd4, 5'b10000};
      4'hC: {len, pat} = {3'd4, 5'b10100};
      4'hD: {len, pat} = {3'd3, 5'b10000};
      4'hE: {len, pat} = {3'd1, 5'b00000};
      4'hF: {len, pat} = {3'd4, 5'b00100};
      default: {len, pat} = 8'h0;
    endcase
  end
  assign dash     = pat[3'd4 - idx_q];
  // last unit index of the current phase: dash and character gap span 3 units
  assign last     = state_q == MARK ? (dash ? 2'd2 : 2'd0) : state_q == CHAR_GAP ? 2'd2 : 2'd0;
  assign tick     = pre_q == UNIT_LAST;
  assign unit_end = tick && unit_q == last;
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    mo_d    = mo_q;
    done_d  = 1'b0;
    pre_d   = (state_q == IDLE || tick) ? 26'd0 : pre_q + 26'd1;
    unit_d  = (state_q == IDLE || unit_end) ? 2'd0 : tick ? unit_q + 2'd1 : unit_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        key_d   = bus.key_val;
        idx_d   = 3'd0;
        state_d = MARK;
        busy_d  = 1'b1;
        mo_d    = 1'b1;
      end
      MARK: if (unit_end) begin
        mo_d    = 1'b0;
        state_d = idx_q == len - 3'd1 ? CHAR_GAP : SPACE;
      end
      SPACE: if (unit_end) begin
        idx_d   = idx_q + 3'd1;
        mo_d    = 1'b1;
        state_d = MARK;
      end
      CHAR_GAP: if (unit_end) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      key_q   <= 4'h0;
      idx_q   <= 3'd0;
      pre_q   <= 26'd0;
      unit_q  <= 2'd0;
      busy_q  <= 1'b0;
      mo_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      unit_q  <= unit_d;
      busy_q  <= busy_d;
      mo_q    <= mo_d;
      done_q  <= done_d;
    end
  end
  assign bus.busy      = busy_q;
  assign bus.morse_out = mo_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed checks of morse_encoder with UNIT_CYCLES=4
module tb_morse_encoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  morse_if bus();
  morse_encoder #(.UNIT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int dn, ndone;
  string tab[16] = '{"-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                     "---..", "----.", ".-", "-...", "-.-.", "-..", ".", "..-."};
  function automatic int enc(input string s);
    int c = 1;
    for (int i = 0; i < s.len(); i++) c = c * 2 + ((s[i] == "-") ? 1 : 0);
    return c;
  endfunction
  function automatic int busy_len(input string s);
    int u = s.len() - 1 + 3;
    for (int i = 0; i < s.len(); i++) u += (s[i] == "-") ? 3 : 1;
    return u * 4;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] k);
    bus.start   = 1'b1;
    bus.key_val = k;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic capture(output int code, output int bcyc, output int lastgap, output int badgap, output int d);
    int run;
    bit cur, weird;
    code = 1; bcyc = 0; run = 0; cur = 1'b1; weird = 1'b0; badgap = 0;
    for (int i = 0; i < 300 && bus.busy === 1'b1; i++) begin
      bcyc++;
      if (bus.morse_out === 1'b1) begin
        if (!cur) begin
          if (run != 4) badgap++;
          run = 0;
          cur = 1'b1;
        end
        run++;
      end else begin
        if (cur) begin
          if (run == 4) code = code * 2;
          else if (run == 12) code = code * 2 + 1;
          else weird = 1'b1;
          run = 0;
          cur = 1'b0;
        end
        run++;
      end
      @(negedge clk);
    end
    if (cur || weird) code = -1;
    lastgap = run;
    d = int'(bus.done);
  endtask
  task automatic expect_char(input string tag, input string s, output int d);
    int code, bcyc, lastgap, badgap;
    capture(code, bcyc, lastgap, badgap, d);
    chk({tag, "_code"}, code, enc(s));
    chk({tag, "_busy"}, bcyc, busy_len(s));
    chk({tag, "_endgap"}, lastgap, 12);
    chk({tag, "_elemgap"}, badgap, 0);
    chk({tag, "_done"}, d, 1);
  endtask
  initial begin
    bus.start   = 1'b0;
    bus.key_val = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out", int'(bus.morse_out), 0);
    chk("rst_done", int'(bus.done), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    send(4'hE);
    expect_char("E", ".", dn);
    @(negedge clk);
    chk("E_done_once", int'(bus.done), 0);
    chk("E_idle", int'(bus.busy), 0);
    send(4'h1);
    expect_char("one", ".----", dn);
    repeat (2) @(negedge clk);
    send(4'h0);
    expect_char("zero", "-----", dn);
    send(4'h5);
    expect_char("five", ".....", dn);
    @(negedge clk);
    send(4'hC);
    fork
      expect_char("C", "-.-.", dn);
      begin
        repeat (9) @(negedge clk);
        bus.start   = 1'b1;
        bus.key_val = 4'h9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (28) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join
    @(negedge clk);
    chk("C_done_once", int'(bus.done), 0);
    chk("C_idle", int'(bus.busy), 0);
    send(4'h7);
    repeat (5) @(negedge clk);
    chk("seven_mid_dash", int'(bus.morse_out), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out", int'(bus.morse_out), 0);
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_done", int'(bus.done), 0);
    chk("post_rst_busy", int'(bus.busy), 0);
    send(4'hA);
    expect_char("A", ".-", dn);
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      send(4'(k));
      expect_char($sformatf("sweep%0d", k), tab[k], dn);
      ndone += dn;
    end
    chk("sweep_dones", ndone, 16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
